// File: rtl/sign_narrower.sv
// Purpose : narrow a signed IN_W word to OUT_W bits, flag and count words that do not fit.
// Latency : 1 cycle from accept to out_valid when the buffer is empty.
// Backpres: 2-entry output buffer; in_ready drops only when both entries are held.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_data/in_valid/in_ready     upstream word and handshake
//   out_data/out_fits/out_valid/out_ready   head of buffer and downstream handshake
//   ovf_cnt, clr_cnt      saturating count of accepted non-fitting words, sync clear
//
// Build option: define SIGN_NARROW_SAT_EN to saturate non-fitting words to the
// most positive / most negative OUT_W value; otherwise they are truncated.

module sign_narrower #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_fits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             clr_cnt
);

  // Bits that must all equal the new sign bit for a lossless narrowing.
  localparam int HI_W = IN_W - OUT_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t             state;

  // Head entry drives the outputs directly; tail is the second slot.
  logic [OUT_W-1:0] head_data;
  logic             head_fits;
  logic [OUT_W-1:0] tail_data;
  logic             tail_fits;

  logic [HI_W-1:0]  in_hi;
  logic             in_fits;
  logic [OUT_W-1:0] in_narrow;
  logic             push;
  logic             pop;

  // ---------------------------------------------------------------------------
  // Fit check and narrowing of the incoming word
  // ---------------------------------------------------------------------------
  assign in_hi   = in_data[IN_W-1:OUT_W-1];
  assign in_fits = (&in_hi) | ~(|in_hi);

`ifdef SIGN_NARROW_SAT_EN
  // Clamp toward the sign of the original word.
  always_comb begin
    in_narrow = in_data[OUT_W-1:0];
    if (!in_fits) begin
      in_narrow = in_data[IN_W-1] ? NEG_MIN : POS_MAX;
    end
  end
`else
  // Plain truncation; the saturation constants are unused in this build.
  assign in_narrow = in_data[OUT_W-1:0];

  logic unused_sat_consts;
  assign unused_sat_consts = ^{POS_MAX, NEG_MIN};
`endif

  // ---------------------------------------------------------------------------
  // Handshakes. in_ready depends only on registered occupancy, so there is no
  // combinational path from out_ready to in_ready.
  // ---------------------------------------------------------------------------
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data  = head_data;
  assign out_fits  = head_fits;

  // ---------------------------------------------------------------------------
  // Occupancy FSM and storage. Head only changes when it is popped or when a
  // word lands in an empty buffer, so the outputs stay stable under stall.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      head_data <= '0;
      head_fits <= 1'b0;
      tail_data <= '0;
      tail_fits <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head_data <= in_narrow;
            head_fits <= in_fits;
            state     <= ONE;
          end
        end

        ONE: begin
          case ({push, pop})
            2'b10: begin
              tail_data <= in_narrow;
              tail_fits <= in_fits;
              state     <= FULL;
            end
            2'b01: begin
              state <= EMPTY;
            end
            2'b11: begin
              // Old head leaves while the new word takes its place.
              head_data <= in_narrow;
              head_fits <= in_fits;
            end
            default: begin
            end
          endcase
        end

        FULL: begin
          // No push possible here: in_ready is low.
          if (pop) begin
            head_data <= tail_data;
            head_fits <= tail_fits;
            state     <= ONE;
          end
        end

        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow event counter. Clear wins over a same-cycle event, and the
  // counter sticks at all-ones instead of wrapping.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (clr_cnt) begin
      ovf_cnt <= '0;
    end else if (push && !in_fits && (ovf_cnt != CNT_MAX)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sign_narrower.sv
// Purpose : randomized and directed stimulus for sign_narrower against a queue model.
// Latency : one stimulus step per clock; inputs and checks on the falling edge.
// Backpres: the model decides accept/pop from its own occupancy, never from the DUT.

module tb_sign_narrower;

`ifdef SIGN_NARROW_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        out_ready;
  logic        clr_cnt;

  logic        in_ready;
  logic [15:0] out_data;
  logic        out_fits;
  logic        out_valid;
  logic [15:0] ovf_cnt;

  // Second instance with a tiny counter to reach saturation quickly.
  logic        in_ready2;
  logic [15:0] out_data2;
  logic        out_fits2;
  logic        out_valid2;
  logic [1:0]  ovf_cnt2;

  always #5 clk = ~clk;

  sign_narrower #(.IN_W(32), .OUT_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_fits(out_fits), .out_valid(out_valid),
    .out_ready(out_ready), .ovf_cnt(ovf_cnt), .clr_cnt(clr_cnt)
  );

  sign_narrower #(.IN_W(32), .OUT_W(16), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .out_data(out_data2), .out_fits(out_fits2), .out_valid(out_valid2),
    .out_ready(out_ready), .ovf_cnt(ovf_cnt2), .clr_cnt(clr_cnt)
  );

  // ---------------------------------------------------------------------------
  // Reference model: a queue of expected outputs and plain integer counters.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] d;
    logic        f;
  } exp_t;

  exp_t        q[$];
  int unsigned cnt_m;
  int unsigned cnt2_m;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic exp_t ref_narrow(input logic [31:0] w);
    exp_t e;
    int   s;
    s   = $signed(w);
    e.f = (s >= -32768) && (s <= 32767);
    if (e.f || !SAT) e.d = w[15:0];
    else if (s < 0)  e.d = 16'h8000;
    else             e.d = 16'h7FFF;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic check_outputs();
    exp_t h;
    check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    check("out_valid_small", {31'd0, out_valid2}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      h = q[0];
      check("out_data", {16'd0, out_data}, {16'd0, h.d});
      check("out_fits", {31'd0, out_fits}, {31'd0, h.f});
    end
    check("ovf_cnt", {16'd0, ovf_cnt}, cnt_m);
    check("ovf_cnt_small", {30'd0, ovf_cnt2}, cnt2_m);
  endtask

  // Apply inputs (on the falling edge), check, advance model across the rising edge.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic c);
    bit   acc;
    bit   pp;
    exp_t e;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clr_cnt   = c;
    check_outputs();
    acc = v && (q.size() < 2);
    pp  = r && (q.size() != 0);
    e   = ref_narrow(d);
    if (pp)  void'(q.pop_front());
    if (acc) q.push_back(e);
    if (c) begin
      cnt_m  = 0;
      cnt2_m = 0;
    end else if (acc && !e.f) begin
      if (cnt_m  < 65535) cnt_m++;
      if (cnt2_m < 3)     cnt2_m++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(0, 4))
      0: w = {16'h0000, 1'b0, 15'($urandom)};
      1: w = {16'hFFFF, 1'b1, 15'($urandom)};
      2: w = 32'($urandom);
      3: w = {16'($urandom_range(0, 1) ? 16'h0000 : 16'hFFFF), 16'($urandom)};
      default: begin
        case ($urandom_range(0, 3))
          0: w = 32'h0000_7FFF;
          1: w = 32'h0000_8000;
          2: w = 32'hFFFF_8000;
          default: w = 32'hFFFF_7FFF;
        endcase
      end
    endcase
    return w;
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    cnt_m     = 0;
    cnt2_m    = 0;
    repeat (2) @(negedge clk);

    // Reset values while rst_n is held low.
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_ovf_cnt", {16'd0, ovf_cnt}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_fits", {31'd0, out_fits}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // First push: 0x0000F000 does not fit, visible the next cycle with count 1.
    step(1'b1, 32'h0000_F000, 1'b0, 1'b0);
    check("first_data", {16'd0, out_data}, SAT ? 32'h7FFF : 32'hF000);
    step(1'b0, '0, 1'b1, 1'b0);

    // Fit cases, each pushed then popped.
    step(1'b1, 32'hFFFF_8310, 1'b0, 1'b0);
    check("neg_fit_data", {16'd0, out_data}, 32'h8310);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0011, 1'b0, 1'b0);
    check("pos_fit_data", {16'd0, out_data}, 32'h0011);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_8000, 1'b0, 1'b0);
    check("edge_ovf_data", {16'd0, out_data}, SAT ? 32'h7FFF : 32'h8000);
    step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: A, B fill the buffer, C is held off until space opens.
    step(1'b1, 32'd1, 1'b0, 1'b0);
    step(1'b1, 32'd2, 1'b0, 1'b0);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    step(1'b1, 32'd3, 1'b0, 1'b0);
    step(1'b1, 32'd3, 1'b0, 1'b0);
    check("bp_head_still_a", {16'd0, out_data}, 32'd1);
    step(1'b1, 32'd3, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Streaming: 20 words back to back.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'(i), 1'b1, 1'b0);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    step(1'b0, '0, 1'b1, 1'b0);

    // Clear beats a same-cycle overflow.
    step(1'b1, 32'h1234_5678, 1'b1, 1'b1);
    check("clr_priority", {16'd0, ovf_cnt}, 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Saturation of the 2-bit counter: five overflows leave it at 3.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h0001_0000 + 32'(i), 1'b1, 1'b0);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    check("sat_small_cnt", {30'd0, ovf_cnt2}, 32'd3);
    check("sat_big_cnt", {16'd0, ovf_cnt}, 32'd5);

    // Asynchronous reset with a full buffer, asserted mid-cycle.
    step(1'b1, 32'h0000_0AAA, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0BBB, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_out_data", {16'd0, out_data}, 32'd0);
    check("arst_ovf_cnt", {16'd0, ovf_cnt}, 32'd0);
    q.delete();
    cnt_m  = 0;
    cnt2_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 32'h0000_0CCC, 1'b0, 1'b0);
    check("arst_next_word", {16'd0, out_data}, 32'h0CCC);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_word(),
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("final_empty", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
